// File: rtl/crtc6545_gen.sv
// 6545/6845-style CRTC timing generator: register file plus horizontal/vertical
// counters producing de, syncs, MA/RA and a frame_start pulse, all registered.
module crtc6545_gen #(
    parameter int   MA_WIDTH  = 14,
    parameter int   RA_WIDTH  = 5,
    parameter int   NUM_REGS  = 16,
    parameter logic HSYNC_POL = 1'b1,
    parameter logic VSYNC_POL = 1'b1
) (
    input  logic                clk16,
    input  logic                res_b,
    input  logic                cclk_en,
    input  logic                cpu_we,
    input  logic                cpu_rd,
    input  logic                rs,
    input  logic [7:0]          data_in,
    output logic [7:0]          data_out,
    output logic                de,
    output logic                hsync,
    output logic                vsync,
    output logic [MA_WIDTH-1:0] ma,
    output logic [RA_WIDTH-1:0] ra,
    output logic                frame_start
);

    typedef enum logic {ST_ROWS, ST_ADJUST} state_t;

    localparam logic [MA_WIDTH-1:0] MA_RESET = MA_WIDTH'(14'h1000);

    function automatic logic [7:0] reg_default(input int idx);
        case (idx)
            0:       return 8'h31;
            1:       return 8'h28;
            2:       return 8'h29;
            3:       return 8'h0F;
            4:       return 8'h28;
            5:       return 8'h05;
            6:       return 8'h19;
            7:       return 8'h21;
            9:       return 8'h07;
            12:      return 8'h10;
            default: return 8'h00;
        endcase
    endfunction

    logic [7:0] regs_q [NUM_REGS];
    logic [4:0] addr_q;
    logic [7:0] data_out_q;
    logic [7:0] r [32];

    // Full 32-entry view so unimplemented addresses read back as zero.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_rview
            if (gi < NUM_REGS) begin : g_impl
                assign r[gi] = regs_q[gi];
            end else begin : g_none
                assign r[gi] = 8'h00;
            end
        end
    endgenerate

    always_ff @(posedge clk16) begin
        if (!res_b) begin
            addr_q     <= '0;
            data_out_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= reg_default(i);
        end else begin
            if (cpu_rd) data_out_q <= r[addr_q];
            if (cpu_we && !rs) addr_q <= data_in[4:0];
            for (int i = 0; i < NUM_REGS; i++) begin
                if (cpu_we && rs && addr_q == 5'(i)) regs_q[i] <= data_in;
            end
        end
    end

    state_t                state_q, state_d;
    logic [7:0]            h_q, h_d, row_q, row_d;
    logic [RA_WIDTH-1:0]   ra_q, ra_d;
    logic [MA_WIDTH-1:0]   ma_row_q, ma_row_d, ma_q, ma_d;
    logic [4:0]            hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic                  de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic                  frame_start_q, frame_start_d, wrap_d, eol;
    logic [7:0]            ra8;
    logic [4:0]            hs_width, vs_width;
    logic [MA_WIDTH-1:0]   ma_start;

    assign eol      = (h_q >= r[0]);
    assign ra8      = 8'(ra_q);
    assign hs_width = (r[3][3:0] == 4'd0) ? 5'd16 : {1'b0, r[3][3:0]};
    assign vs_width = (r[3][7:4] == 4'd0) ? 5'd16 : {1'b0, r[3][7:4]};
    assign ma_start = MA_WIDTH'({r[12][5:0], r[13]});

    always_ff @(posedge clk16) begin
        if (!res_b) begin
            state_q       <= ST_ROWS;
            h_q           <= '0;
            row_q         <= '0;
            ra_q          <= '0;
            ma_row_q      <= MA_RESET;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            de_q          <= 1'b0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            ma_q          <= MA_RESET;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            row_q         <= row_d;
            ra_q          <= ra_d;
            ma_row_q      <= ma_row_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            frame_start_q <= frame_start_d;
            if (cclk_en) begin
                de_q    <= de_d;
                hsync_q <= hsync_d;
                vsync_q <= vsync_d;
                ma_q    <= ma_d;
            end
        end
    end

    // Frame wrap is an action on the end-of-line edge, not a resting state.
    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        row_d    = row_q;
        ra_d     = ra_q;
        ma_row_d = ma_row_q;
        hcnt_d   = hcnt_q;
        vcnt_d   = vcnt_q;
        wrap_d   = 1'b0;
        if (cclk_en) begin
            h_d = eol ? 8'd0 : h_q + 8'd1;
            if (h_d == r[2])        hcnt_d = hs_width;
            else if (hcnt_q != '0)  hcnt_d = hcnt_q - 5'd1;
            if (eol) begin
                case (state_q)
                    ST_ROWS: begin
                        if (ra8 >= r[9]) begin
                            ra_d     = '0;
                            row_d    = row_q + 8'd1;
                            ma_row_d = ma_row_q + MA_WIDTH'(r[1]);
                            if (row_q >= r[4]) begin
                                if (r[5] != 8'd0) state_d = ST_ADJUST;
                                else              wrap_d  = 1'b1;
                            end
                        end else begin
                            ra_d = ra_q + RA_WIDTH'(1);
                        end
                    end
                    ST_ADJUST: begin
                        if ({1'b0, ra8} + 9'd1 >= {1'b0, r[5]}) wrap_d = 1'b1;
                        else                                      ra_d   = ra_q + RA_WIDTH'(1);
                    end
                    default: state_d = ST_ROWS;
                endcase
                if (wrap_d) begin
                    row_d    = '0;
                    ra_d     = '0;
                    ma_row_d = ma_start;
                    state_d  = ST_ROWS;
                end
                if (state_d == ST_ROWS && row_d == r[7] && ra_d == '0) vcnt_d = vs_width;
                else if (vcnt_q != '0)                                  vcnt_d = vcnt_q - 5'd1;
            end
        end
    end

    always_comb begin
        de_d          = (h_d < r[1]) && (row_d < r[6]) && (state_d == ST_ROWS);
        hsync_d       = (hcnt_d != '0) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d       = (vcnt_d != '0) ? VSYNC_POL : ~VSYNC_POL;
        ma_d          = ma_row_d + MA_WIDTH'(h_d);
        frame_start_d = wrap_d;
    end

    assign data_out    = data_out_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign ma          = ma_q;
    assign ra          = ra_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_crtc6545_gen.sv
// Randomised bench for crtc6545_gen: a frame-position reference model feeds a
// scoreboard queue that a separate monitor drains on every character edge.
module tb_crtc6545_gen;

    logic        clk16 = 1'b0;
    logic        res_b, cclk_en, cpu_we, cpu_rd, rs;
    logic [7:0]  data_in, data_out;
    logic        de, hsync, vsync, frame_start;
    logic [13:0] ma;
    logic [4:0]  ra;

    always #5 clk16 = ~clk16;

    crtc6545_gen dut (
        .clk16(clk16), .res_b(res_b), .cclk_en(cclk_en), .cpu_we(cpu_we),
        .cpu_rd(cpu_rd), .rs(rs), .data_in(data_in), .data_out(data_out),
        .de(de), .hsync(hsync), .vsync(vsync), .ma(ma), .ra(ra),
        .frame_start(frame_start)
    );

    typedef struct packed {
        logic        rst;
        logic        de;
        logic        hs;
        logic        vs;
        logic [13:0] ma;
        logic [4:0]  ra;
        logic        fs;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] rd_q[$];
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, req);
        end
    endtask

    // Reference model: position is (char in line, line in frame); row/ra/ma follow by division.
    int m_r [32];
    int m_addr, m_h, m_line, hs_age, vs_age;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_r[i] = 0;
        m_r[0] = 'h31; m_r[1] = 'h28; m_r[2] = 'h29; m_r[3] = 'h0F; m_r[4] = 'h28;
        m_r[5] = 'h05; m_r[6] = 'h19; m_r[7] = 'h21; m_r[9] = 'h07; m_r[12] = 'h10;
        m_addr = 0; m_h = 0; m_line = 0; hs_age = 1000; vs_age = 1000;
    endfunction

    function automatic exp_t model_advance();
        exp_t e;
        int   rpl, rows_lines, total, row, rav, start, hw, vw;
        bit   in_rows, eol, wrapped;
        rpl        = m_r[9] + 1;
        rows_lines = (m_r[4] + 1) * rpl;
        total      = rows_lines + m_r[5];
        eol        = (m_h >= m_r[0]);
        wrapped    = 1'b0;
        if (eol) begin
            m_h = 0;
            if (m_line + 1 >= total) begin m_line = 0; wrapped = 1'b1; end
            else m_line++;
        end else begin
            m_h++;
        end
        in_rows = (m_line < rows_lines);
        row     = in_rows ? m_line / rpl : m_r[4] + 1;
        rav     = in_rows ? m_line % rpl : m_line - rows_lines;
        hw      = (m_r[3] % 16 == 0) ? 16 : m_r[3] % 16;
        vw      = (m_r[3] / 16 == 0) ? 16 : m_r[3] / 16;
        if (m_h == m_r[2]) hs_age = 0;
        else if (hs_age < 1000) hs_age++;
        if (eol) begin
            if (in_rows && row == m_r[7] && rav == 0) vs_age = 0;
            else if (vs_age < 1000) vs_age++;
        end
        start = (m_r[12] % 64) * 256 + m_r[13];
        e.rst = 1'b0;
        e.de  = (m_h < m_r[1]) && in_rows && (row < m_r[6]);
        e.hs  = (hs_age < hw);
        e.vs  = (vs_age < vw);
        e.ma  = 14'((start + row * m_r[1] + m_h) % 16384);
        e.ra  = 5'(rav);
        e.fs  = wrapped;
        return e;
    endfunction

    exp_t model_e;
    always @(posedge clk16) begin
        if (!res_b) begin
            model_reset();
            model_e = '{rst: 1'b1, de: 1'b0, hs: 1'b0, vs: 1'b0, ma: 14'h1000, ra: 5'd0, fs: 1'b0};
            exp_q.push_back(model_e);
        end else begin
            if (cpu_rd) rd_q.push_back((m_addr < 16) ? 8'(m_r[m_addr]) : 8'h00);
            if (cclk_en) exp_q.push_back(model_advance());
            if (cpu_we) begin
                if (!rs) m_addr = int'(data_in[4:0]);
                else if (m_addr < 16) m_r[m_addr] = int'(data_in);
            end
        end
    end

    // Monitor: the DUT presents new outputs on any reset or character edge.
    logic pres_mon = 1'b0, rd_mon = 1'b0;
    exp_t mon_e;
    always @(posedge clk16) begin
        pres_mon = !res_b || cclk_en;
        rd_mon   = res_b && cpu_rd;
    end
    always @(negedge clk16) begin
        if (pres_mon) begin
            if (exp_q.size() == 0) chk("exp_queue_empty", 1, 0);
            else begin
                mon_e = exp_q.pop_front();
                chk("de", de, mon_e.de);
                chk("hsync", hsync, mon_e.hs);
                chk("vsync", vsync, mon_e.vs);
                chk("ma", ma, mon_e.ma);
                chk("ra", ra, mon_e.ra);
                chk("frame_start", frame_start, mon_e.fs);
                if (mon_e.rst) chk("data_out_reset", data_out, 0);
            end
        end
        if (rd_mon) begin
            if (rd_q.size() == 0) chk("rd_queue_empty", 1, 0);
            else chk("data_out", data_out, rd_q.pop_front());
        end
    end

    task automatic step(input bit en, input bit we, input bit rd, input bit rsv, input logic [7:0] d);
        @(negedge clk16);
        cclk_en = en; cpu_we = we; cpu_rd = rd; rs = rsv; data_in = d;
        @(posedge clk16);
        #1;
    endtask

    task automatic wr(input bit rsv, input logic [7:0] d);
        step(1'b0, 1'b1, 1'b0, rsv, d);
    endtask

    task automatic run_rand(input int n);
        for (int i = 0; i < n; i++) step($urandom_range(0, 7) != 0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic run_until_frame(output int chars);
        bit en, seen;
        chars = 0;
        seen  = 1'b0;
        for (int c = 0; c < 40000 && !seen; c++) begin
            en = ($urandom_range(0, 7) != 0);
            step(en, 1'b0, 1'b0, 1'b0, 8'h00);
            if (en) chars++;
            if (frame_start) seen = 1'b1;
        end
        if (!seen) chk("frame_start_timeout", 0, 1);
    endtask

    int chars;
    logic [7:0] a;

    initial begin
        res_b = 1'b0; cclk_en = 1'b0; cpu_we = 1'b0; cpu_rd = 1'b0; rs = 1'b0; data_in = 8'h00;
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk16);
        res_b = 1'b1;

        // Character clock every 16 system clocks for the first lines
        for (int i = 0; i < 110; i++) begin
            repeat (15) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        end
        run_until_frame(chars);
        chk("frame_chars_default", chars + 110, 50 * 333);

        // No vertical adjust
        wr(1'b0, 8'h05);
        wr(1'b1, 8'h00);
        run_until_frame(chars);
        chk("frame_chars_no_adjust", chars, 50 * 328);

        // Wider line, unimplemented register, random readback
        wr(1'b0, 8'h00);
        wr(1'b1, 8'h3F);
        run_rand(150);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        wr(1'b0, 8'h1F);
        wr(1'b1, 8'hAA);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 8; i++) begin
            a = 8'($urandom_range(0, 31));
            wr(1'b0, a);
            if (a == 8'd14 || a == 8'd15) wr(1'b1, 8'($urandom_range(0, 255)));
            step(1'b0, 1'b1, 1'b1, 1'b1, 8'($urandom_range(0, 255)) & 8'h00 | 8'(m_r[a]));
            run_rand(20);
        end
        wr(1'b0, 8'h00);
        wr(1'b1, 8'h31);
        run_rand(120);

        // Shrink R0 below the current h
        for (int k = 0; k < 200 && m_h != 20; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("reach_h20", m_h, 20);
        wr(1'b1, 8'h05);
        run_rand(40);
        wr(1'b1, 8'h31);
        run_rand(600);

        // One-cycle reset mid-frame
        @(negedge clk16);
        res_b = 1'b0; cclk_en = 1'b1;
        @(posedge clk16);
        #1;
        @(negedge clk16);
        res_b = 1'b1;
        run_rand(300);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("exp_queue_drained", exp_q.size(), 0);
        chk("rd_queue_drained", rd_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
